// File: rtl/ddr_wr_scheduler_if.sv
// Block-side and DDR-side signal bundle for ddr_wr_scheduler.
// master = scheduler, slave = requesting blocks plus DDR controller.
interface ddr_wr_scheduler_if #(
  parameter int unsigned NUM             = 2,
  parameter int unsigned MAX_WIDTH_Vaddr = 20,
  parameter int unsigned WIDTH_ddr_addr  = 25
);
  logic [NUM-1:0]                 block_req;
  logic [NUM*MAX_WIDTH_Vaddr-1:0] flat__block_Vaddr;
  logic [NUM*18-1:0]              flat__data18bit;
  logic [NUM-1:0]                 data18bit_vld;
  logic [NUM-1:0]                 block_granted;
  logic [NUM-1:0]                 data_rdy;
  logic                           ddr_req;
  logic                           ddr_ack;
  logic [WIDTH_ddr_addr-1:0]      ddr_addr;
  logic [WIDTH_ddr_addr-1:0]      ddr_len;
  logic [15:0]                    ddr_wr_data;
  logic                           ddr_wr_en;
  logic                           ddr_wr_rdy;

  modport master (
    input  block_req, flat__block_Vaddr, flat__data18bit, data18bit_vld, ddr_ack, ddr_wr_rdy,
    output block_granted, data_rdy, ddr_req, ddr_addr, ddr_len, ddr_wr_data, ddr_wr_en
  );

  modport slave (
    output block_req, flat__block_Vaddr, flat__data18bit, data18bit_vld, ddr_ack, ddr_wr_rdy,
    input  block_granted, data_rdy, ddr_req, ddr_addr, ddr_len, ddr_wr_data, ddr_wr_en
  );
endinterface

// File: rtl/ddr_wr_scheduler.sv
// Arbitrates block write batches onto one DDR port, packing 18-bit words into 16-bit beats.
// Define DDRWR_ROUNDROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module ddr_wr_scheduler #(
  parameter int unsigned NUM                    = 2,
  parameter int unsigned DS_data_NUM_in_1_batch = 224,
  parameter int unsigned WIDTH_ddr_addr         = 25,
  parameter int unsigned MAX_WIDTH_Vaddr        = 20,
  parameter int unsigned BASE_ADDR0             = 0,
  parameter int unsigned BASE_ADDR1             = 13824
) (
  input logic                clk,
  input logic                reset,
  ddr_wr_scheduler_if.master bus
);

  localparam int unsigned LenWords = DS_data_NUM_in_1_batch * 9 / 8;
  localparam int unsigned IdxW     = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned InCntW   = $clog2(DS_data_NUM_in_1_batch + 1);
  localparam int unsigned OutCntW  = $clog2(LenWords + 1);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           grant_idx_q;
  logic [NUM-1:0]            granted_q;
  logic                      ddr_req_q;
  logic [WIDTH_ddr_addr-1:0] ddr_addr_q;
  logic [WIDTH_ddr_addr-1:0] ddr_len_q;
  logic [33:0]               acc_q, acc_d;
  logic [5:0]                fill_q, fill_d;
  logic [InCntW-1:0]         in_cnt_q;
  logic [OutCntW-1:0]        out_cnt_q;

  logic                      pick_valid;
  logic [IdxW-1:0]           pick_idx;
  logic [MAX_WIDTH_Vaddr-1:0] vaddr_sel;
  logic [MAX_WIDTH_Vaddr-1:0] vaddr_trunc;
  logic [WIDTH_ddr_addr-1:0] base_sel;
  logic [WIDTH_ddr_addr-1:0] addr_calc;

  logic [17:0]               data_sel;
  logic                      vld_sel;
  logic                      xfer;
  logic [5:0]                fill_after;
  logic                      can_accept;
  logic                      accept;
  logic                      last_xfer;
  logic [33:0]               acc_shift;

`ifdef DDRWR_ROUNDROBIN_EN
  logic [IdxW-1:0]           rr_start_q;
  logic [IdxW-1:0]           cand;

  // Search starts one above the last granted block and wraps.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      cand = IdxW'((int'(rr_start_q) + i) % int'(NUM));
      if (!pick_valid && bus.block_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`else
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (!pick_valid && bus.block_req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(i);
      end
    end
  end
`endif

  // Vaddr is in 18-bit word units; each 8 words occupy 9 DDR words.
  always_comb begin
    vaddr_sel   = bus.flat__block_Vaddr[pick_idx*MAX_WIDTH_Vaddr +: MAX_WIDTH_Vaddr];
    vaddr_trunc = vaddr_sel & ~MAX_WIDTH_Vaddr'(7);
    base_sel    = (pick_idx == '0) ? WIDTH_ddr_addr'(BASE_ADDR0) : WIDTH_ddr_addr'(BASE_ADDR1);
    addr_calc   = base_sel + WIDTH_ddr_addr'(vaddr_trunc) + WIDTH_ddr_addr'(vaddr_trunc >> 3);
  end

  always_comb begin
    data_sel   = bus.flat__data18bit[grant_idx_q*18 +: 18];
    vld_sel    = bus.data18bit_vld[grant_idx_q];
    xfer       = (fill_q >= 6'd16) && bus.ddr_wr_rdy;
    fill_after = xfer ? (fill_q - 6'd16) : fill_q;
    // Admit a word only if it still fits in 34 bits after this cycle's beat leaves.
    can_accept = (state_q == StXfer) && (in_cnt_q < InCntW'(DS_data_NUM_in_1_batch)) &&
                 (fill_after <= 6'd16);
    accept     = can_accept && vld_sel;
    acc_shift  = xfer ? (acc_q >> 16) : acc_q;
    acc_d      = acc_shift | (accept ? (34'(data_sel) << fill_after) : 34'd0);
    fill_d     = fill_after + (accept ? 6'd18 : 6'd0);
    last_xfer  = xfer && (out_cnt_q == OutCntW'(LenWords - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      granted_q   <= '0;
      ddr_req_q   <= 1'b0;
      ddr_addr_q  <= '0;
      ddr_len_q   <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
`ifdef DDRWR_ROUNDROBIN_EN
      rr_start_q  <= '0;
`endif
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      if (accept) in_cnt_q <= in_cnt_q + 1'b1;
      if (xfer)   out_cnt_q <= out_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q     <= StReq;
            grant_idx_q <= pick_idx;
            granted_q   <= NUM'(1) << pick_idx;
            ddr_req_q   <= 1'b1;
            ddr_addr_q  <= addr_calc;
            ddr_len_q   <= WIDTH_ddr_addr'(LenWords);
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
`ifdef DDRWR_ROUNDROBIN_EN
            rr_start_q  <= (pick_idx == IdxW'(NUM - 1)) ? '0 : pick_idx + 1'b1;
`endif
          end
        end
        StReq: begin
          if (bus.ddr_ack) begin
            state_q   <= StXfer;
            ddr_req_q <= 1'b0;
          end
        end
        StXfer: begin
          // Batch ends on word count alone; block_req is not consulted here.
          if (last_xfer) begin
            state_q   <= StIdle;
            granted_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.block_granted = granted_q;
  assign bus.data_rdy      = can_accept ? granted_q : '0;
  assign bus.ddr_req       = ddr_req_q;
  assign bus.ddr_addr      = ddr_addr_q;
  assign bus.ddr_len       = ddr_len_q;
  assign bus.ddr_wr_data   = acc_q[15:0];
  assign bus.ddr_wr_en     = (fill_q >= 6'd16);

endmodule

// File: tb/tb_ddr_wr_scheduler.sv
// Directed bench for ddr_wr_scheduler with a bit-stream scoreboard of expected 16-bit beats.
module tb_ddr_wr_scheduler;

  localparam int NUM   = 2;
  localparam int DS    = 224;
  localparam int LEN   = 252;
  localparam int AW    = 25;
  localparam int VW    = 20;
  localparam int BASE1 = 13824;
`ifdef DDRWR_ROUNDROBIN_EN
  localparam int ArbK    = 1;
  localparam int ArbAddr = BASE1 + 40 + 5;
`else
  localparam int ArbK    = 0;
  localparam int ArbAddr = 8 + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ddr_wr_scheduler_if #(.NUM(NUM), .MAX_WIDTH_Vaddr(VW), .WIDTH_ddr_addr(AW)) bus ();

  ddr_wr_scheduler #(
    .NUM                   (NUM),
    .DS_data_NUM_in_1_batch(DS),
    .WIDTH_ddr_addr        (AW),
    .MAX_WIDTH_Vaddr       (VW),
    .BASE_ADDR0            (0),
    .BASE_ADDR1            (BASE1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks;
  int          errors;
  logic [15:0] exp_q[$];
  logic [63:0] m_acc;
  int          m_fill;
  int          m_in;
  int          m_out;
  int          dut_fill;
  logic [17:0] batch_data[DS];
  logic [15:0] first_words[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed event missing, expected event present", tag);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_granted"}, 64'(bus.block_granted), 0);
    chk({pfx, "_data_rdy"}, 64'(bus.data_rdy), 0);
    chk({pfx, "_ddr_req"}, 64'(bus.ddr_req), 0);
    chk({pfx, "_wr_en"}, 64'(bus.ddr_wr_en), 0);
    chk({pfx, "_addr"}, 64'(bus.ddr_addr), 0);
    chk({pfx, "_len"}, 64'(bus.ddr_len), 0);
    chk({pfx, "_wr_data"}, 64'(bus.ddr_wr_data), 0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_acc    = '0;
    m_fill   = 0;
    m_in     = 0;
    m_out    = 0;
    dut_fill = 0;
  endtask

  // Reference packing: append 18 bits above the residue, emit every full 16-bit beat.
  task automatic model_push(input logic [17:0] w);
    m_acc  = m_acc | (64'(w) << m_fill);
    m_fill = m_fill + 18;
    while (m_fill >= 16) begin
      exp_q.push_back(m_acc[15:0]);
      m_acc  = m_acc >> 16;
      m_fill = m_fill - 16;
    end
  endtask

  task automatic set_data(input bit directed);
    for (int i = 0; i < DS; i++) batch_data[i] = directed ? 18'h0 : 18'($urandom);
    if (directed) batch_data[0] = 18'h3FFFF;
  endtask

  task automatic start_batch(input logic [1:0] req, input logic [19:0] v0, input logic [19:0] v1,
                             input int exp_k, input int exp_addr, input int ack_delay,
                             input bit drop_req);
    @(negedge clk);
    bus.block_req         = req;
    bus.flat__block_Vaddr = {v1, v0};
    bus.data18bit_vld     = '0;
    bus.ddr_ack           = 1'b0;
    bus.ddr_wr_rdy        = 1'b1;
    for (int d = 0; d < ack_delay; d++) begin
      @(negedge clk);
      #1;
      chk("ddr_req_held", 64'(bus.ddr_req), 1);
      chk("ddr_addr", 64'(bus.ddr_addr), 64'(exp_addr));
      chk("ddr_len", 64'(bus.ddr_len), LEN);
      chk("grant", 64'(bus.block_granted), 64'(1 << exp_k));
      if (d == ack_delay - 1) bus.ddr_ack = 1'b1;
    end
    @(negedge clk);
    bus.ddr_ack = 1'b0;
    #1;
    chk("ddr_req_drop", 64'(bus.ddr_req), 0);
    if (drop_req) bus.block_req = '0;
  endtask

  task automatic run_xfer(input int k, input int stall_at, input int stall_len,
                          input bit rand_vld, input int abort_at, input bit check_rate);
    int          cyc      = 0;
    int          first_acc = -1;
    int          first_en  = -1;
    int          last_x    = -1;
    bit          rdy, xfer_exp, acc, prev_held;
    logic [1:0]  exp_rdy;
    logic [15:0] prev_data;
    prev_held = 1'b0;
    prev_data = '0;
    while (m_out < LEN && cyc < 3000) begin
      @(negedge clk);
      if (abort_at >= 0 && m_in == abort_at) return;
      rdy                        = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bus.ddr_wr_rdy             = rdy;
      bus.flat__data18bit        = {18'($urandom), 18'($urandom)};
      bus.data18bit_vld          = '0;
      bus.data18bit_vld[1 - k]   = 1'b1;
      if (m_in < DS) begin
        bus.flat__data18bit[k*18 +: 18] = batch_data[m_in];
        bus.data18bit_vld[k]            = rand_vld ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      xfer_exp = (dut_fill >= 16) && rdy;
      chk("wr_en", 64'(bus.ddr_wr_en), 64'(dut_fill >= 16));
      exp_rdy = '0;
      if (m_in < DS && (dut_fill - (xfer_exp ? 16 : 0)) <= 16) exp_rdy[k] = 1'b1;
      chk("data_rdy", 64'(bus.data_rdy), 64'(exp_rdy));
      if (prev_held) chk("wr_data_hold", 64'(bus.ddr_wr_data), 64'(prev_data));
      acc = bus.data_rdy[k] && bus.data18bit_vld[k];
      if (bus.ddr_wr_en && rdy) begin
        if (exp_q.size() == 0) fail_now("wr_data_extra_beat");
        else chk("wr_data", 64'(bus.ddr_wr_data), 64'(exp_q.pop_front()));
        if (m_out < 2) first_words[m_out] = bus.ddr_wr_data;
        m_out++;
        dut_fill = dut_fill - 16;
        last_x   = cyc;
      end
      if (acc) begin
        model_push(batch_data[m_in]);
        m_in++;
        dut_fill = dut_fill + 18;
        if (first_acc < 0) first_acc = cyc;
      end
      if (bus.ddr_wr_en && first_en < 0) first_en = cyc;
      prev_held = bus.ddr_wr_en && !rdy;
      prev_data = bus.ddr_wr_data;
      cyc++;
    end
    if (m_out < LEN) fail_now("batch_timeout");
    if (check_rate) begin
      chk("first_wr_en_latency", 64'(first_en - first_acc), 1);
      chk("batch_cycles", 64'(last_x - first_acc), LEN);
    end
    @(negedge clk);
    #1;
    bus.block_req = '0;
    chk("end_granted", 64'(bus.block_granted), 0);
    chk("end_data_rdy", 64'(bus.data_rdy), 0);
    chk("end_wr_en", 64'(bus.ddr_wr_en), 0);
    chk("end_words_in", 64'(m_in), DS);
    chk("end_fill", 64'(dut_fill), 0);
    chk("end_scoreboard", 64'(exp_q.size()), 0);
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    reset                 = 1'b0;
    bus.block_req         = '0;
    bus.flat__block_Vaddr = '0;
    bus.flat__data18bit   = '0;
    bus.data18bit_vld     = '0;
    bus.ddr_ack           = 1'b0;
    bus.ddr_wr_rdy        = 1'b1;
    first_words[0]        = '0;
    first_words[1]        = '0;
    model_clear();

    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Block 0, directed pattern, full-rate stream.
    set_data(1'b1);
    model_clear();
    start_batch(2'b01, 20'd0, 20'd0, 0, 0, 1, 1'b0);
    run_xfer(0, -100, 0, 1'b0, -1, 1'b1);
    chk("first_beat", 64'(first_words[0]), 64'h FFFF);
    chk("second_beat", 64'(first_words[1]), 64'h 0003);

    // Both request right after block 0 was served; request dropped mid-batch.
    set_data(1'b0);
    model_clear();
    start_batch(2'b11, 20'd8, 20'd40, ArbK, ArbAddr, 2, 1'b1);
    run_xfer(ArbK, -100, 0, 1'b1, -1, 1'b0);

    // Block 1 at Vaddr 16, ack after 4 cycles, 5-cycle DDR stall mid-batch.
    set_data(1'b0);
    model_clear();
    start_batch(2'b10, 20'd0, 20'd16, 1, BASE1 + 18, 4, 1'b0);
    run_xfer(1, 40, 5, 1'b1, -1, 1'b0);

    // Reset asserted at word 100 of a batch.
    set_data(1'b0);
    model_clear();
    start_batch(2'b01, 20'd0, 20'd0, 0, 0, 1, 1'b0);
    run_xfer(0, -100, 0, 1'b0, 100, 1'b0);
    reset         = 1'b0;
    bus.block_req = '0;
    #1;
    chk_outputs_zero("midbatch_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // After reset the lowest requester wins; Vaddr 21 truncates to 16.
    set_data(1'b0);
    model_clear();
    start_batch(2'b11, 20'd21, 20'd21, 0, 18, 1, 1'b0);
    run_xfer(0, 60, 5, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_wr_scheduler.md
DDR_WR_SCHEDULER -- requirements
Module: ddr_wr_scheduler

Interface
- REQ-001: NUM, 2, number of block write ports.
- REQ-002: DS_data_NUM_in_1_batch, 224, 18-bit words per batch; SHALL be a multiple of 8.
- REQ-003: WIDTH_ddr_addr, 25, width of ddr_addr/ddr_len.
- REQ-004: MAX_WIDTH_Vaddr, 20, width of each block Vaddr (18-bit word units).
- REQ-005: BASE_ADDR0 / BASE_ADDR1, 0 / 13824, per-block DDR base in 16-bit word units.
- REQ-006: clk  in  1  single clock; all logic on rising edge.
- REQ-007: reset  in  1  asynchronous, active-low reset.
- REQ-008: block_req  in  NUM  per-block write request, held until its batch completes.
- REQ-009: flat__block_Vaddr  in  NUM*MAX_WIDTH_Vaddr  per-block batch start Vaddr; block k at [(k+1)*MAX_WIDTH_Vaddr-1 -: MAX_WIDTH_Vaddr].
- REQ-010: flat__data18bit  in  NUM*18  per-block write data; block k at [(k+1)*18-1 -: 18].
- REQ-011: data18bit_vld  in  NUM  per-block data valid.
- REQ-012: block_granted  out  NUM  one-hot grant, high for the whole batch.
- REQ-013: data_rdy  out  NUM  word accepted from block k when data_rdy[k] & data18bit_vld[k].
- REQ-014: ddr_req / ddr_ack  out / in  1 / 1  write-request handshake.
- REQ-015: ddr_addr / ddr_len  out  WIDTH_ddr_addr each  DDR start address / length in 16-bit words.
- REQ-016: ddr_wr_data / ddr_wr_en / ddr_wr_rdy  out / out / in  16 / 1 / 1  DDR write stream; word transfers when ddr_wr_en & ddr_wr_rdy.

Function
- REQ-017: FSM states IDLE, REQ, XFER; IDLE->REQ on any block_req, latching the grant; REQ->XFER on ddr_ack; XFER->IDLE the cycle after the last of DS_data_NUM_in_1_batch*9/8 words transfers.
- REQ-018: In REQ, ddr_req SHALL be held high with ddr_addr = BASE_ADDRk + Vaddr + Vaddr/8 and ddr_len = DS_data_NUM_in_1_batch*9/8 (252 by default), all stable until ddr_ack.
- REQ-019: Vaddr not a multiple of 8 SHALL be truncated down to a multiple of 8 before address computation.
- REQ-020: Packer holds a bit accumulator (max 34 bits) with fill count; each accepted 18-bit word is appended above the existing bits (LSB-first bit stream).
- REQ-021: ddr_wr_en SHALL be high exactly when fill >= 16; ddr_wr_data = accumulator[15:0]; a transfer removes 16 bits.
- REQ-022: data_rdy[k] SHALL be high only in XFER for the granted k, while fewer than DS_data_NUM_in_1_batch words have been accepted, and while fill minus (16 if a transfer occurs this cycle) <= 16.
- REQ-023: Latency: the first ddr_wr_en SHALL assert the cycle after the first accepted word; sustained throughput is 8 inputs per 9 cycles with ddr_wr_rdy high.
- REQ-024: With ddr_wr_rdy low, ddr_wr_data SHALL hold and input SHALL stall once fill > 16; no data SHALL be lost or duplicated.
- REQ-025: At batch end fill SHALL be exactly 0; block_granted drops on the XFER->IDLE transition.
- REQ-026: A block_req deasserted mid-batch SHALL be ignored; the batch completes by word count.

Reset
- REQ-027: reset low SHALL immediately force IDLE, clear accumulator, fill, counters and arbitration pointer, and drive block_granted, data_rdy, ddr_req, ddr_wr_en, ddr_addr, ddr_len and ddr_wr_data to 0, including mid-batch.
- REQ-028: After reset release, the first grant SHALL go to the lowest-index requesting block.

Configuration
- REQ-029: DDRWR_ROUNDROBIN_EN defined: arbitration SHALL be round-robin, starting the search one index above the last granted block.
- REQ-030: DDRWR_ROUNDROBIN_EN undefined: fixed priority, lowest index wins.

Verification
- REQ-031: Block 0 sends 18'h3FFFF then 18'h00000, rest zero -> ddr_wr_data 16'hFFFF then 16'h0003; 252 words total; fill ends at 0.
- REQ-032: Block 1 Vaddr=16, req -> ddr_addr=13842, ddr_len=252; ddr_req held 4 cycles until ddr_ack.
- REQ-033: Both req; block 0 just served -> block 1 granted with macro, block 0 without.
- REQ-034: ddr_wr_rdy low 5 cycles mid-batch -> ddr_wr_data stable, data_rdy low once fill > 16; output stream matches the reference packing model.
- REQ-035: reset low at word 100 of a batch -> all outputs 0 next edge; new req after release restarts from IDLE with correct address.
